// File: rtl/noc_vc_output_port_if.sv
// Bundles the input-side flit handshakes, the registered output link and the status flags of one router output port.
// The router drives the port through the master modport and the output port itself uses the slave modport.
interface noc_vc_output_port_if #(
  parameter int NUM_INPUTS   = 5,
  parameter int CHANNELS     = 2,
  parameter int FLIT_WIDTH   = 64,
  parameter int CREDIT_DEPTH = 4
);
  localparam int VCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [NUM_INPUTS-1:0]            in_valid;
  logic [NUM_INPUTS*VCW-1:0]        in_vc;
  logic [NUM_INPUTS*FLIT_WIDTH-1:0] in_flit;
  logic [NUM_INPUTS-1:0]            in_sop;
  logic [NUM_INPUTS-1:0]            in_eop;
  logic [NUM_INPUTS-1:0]            in_ready;
  logic                             out_valid;
  logic [VCW-1:0]                   out_vc;
  logic [FLIT_WIDTH-1:0]            out_flit;
  logic                             out_sop;
  logic                             out_eop;
  logic [CHANNELS-1:0]              credit_return;
  logic [CHANNELS-1:0]              vc_busy;
  logic                             credit_err;
  logic                             proto_err;

  modport slave (
    input  in_valid, in_vc, in_flit, in_sop, in_eop, credit_return,
    output in_ready, out_valid, out_vc, out_flit, out_sop, out_eop,
    output vc_busy, credit_err, proto_err
  );

  modport master (
    output in_valid, in_vc, in_flit, in_sop, in_eop, credit_return,
    input  in_ready, out_valid, out_vc, out_flit, out_sop, out_eop,
    input  vc_busy, credit_err, proto_err
  );
endinterface

// File: rtl/noc_vc_output_port.sv
// Round-robin switch allocation with per-VC wormhole locks and credits onto one registered link.
// The grant is combinational, the flit appears 1 cycle later, and the link is throttled only by downstream credits.
module noc_vc_output_port #(
  parameter int NUM_INPUTS   = 5,
  parameter int CHANNELS     = 2,
  parameter int FLIT_WIDTH   = 64,
  parameter int CREDIT_DEPTH = 4
) (
  input logic noc_clk,
  input logic noc_rst_n,
  noc_vc_output_port_if.slave bus
);
  localparam int VCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW  = $clog2(CREDIT_DEPTH + 1);
  localparam int IW  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef struct packed {
    logic                  vld;
    logic [VCW-1:0]        vc;
    logic                  sop;
    logic                  eop;
    logic [FLIT_WIDTH-1:0] flit;
  } out_t;

  logic [CW-1:0]         credit_q [CHANNELS];
  logic [CW-1:0]         credit_d [CHANNELS];
  logic [IW-1:0]         lock_own_q [CHANNELS];
  logic [IW-1:0]         lock_own_d [CHANNELS];
  logic [CHANNELS-1:0]   lock_vld_q, lock_vld_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [NUM_INPUTS-1:0] stall_q, stall_d;
  logic                  credit_err_q, credit_err_d;
  logic                  proto_err_q, proto_err_d;
  logic                  run_q;
  out_t                  out_q, out_d;

  logic [NUM_INPUTS-1:0] elig, perr, grant;
  logic [VCW-1:0]        el_vc;
  logic                  gnt_any;
  logic [IW-1:0]         gnt_idx;
  int                    rr_idx;
  logic [VCW-1:0]        g_vc;
  logic                  g_sop, g_eop;
  logic [FLIT_WIDTH-1:0] g_flit;

  // run_q keeps grants off while reset is asserted and for the first cycle after release
  always_comb begin
    elig  = '0;
    perr  = '0;
    el_vc = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      el_vc = bus.in_vc[i*VCW +: VCW];
      if (int'(el_vc) < CHANNELS) begin
        if (bus.in_valid[i] && !bus.in_sop[i] && !lock_vld_q[el_vc]) begin
          perr[i] = 1'b1;
        end
        if (bus.in_valid[i] && !stall_q[i] && run_q && (credit_q[el_vc] != '0)) begin
          if (bus.in_sop[i] && !lock_vld_q[el_vc]) begin
            elig[i] = 1'b1;
          end else if (!bus.in_sop[i] && lock_vld_q[el_vc] && (lock_own_q[el_vc] == IW'(i))) begin
            elig[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      rr_idx = int'(ptr_q) + k;
      if (rr_idx >= NUM_INPUTS) begin
        rr_idx = rr_idx - NUM_INPUTS;
      end
      if (!gnt_any && elig[rr_idx[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx[IW-1:0];
      end
    end
    if (gnt_any) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    g_vc   = '0;
    g_sop  = 1'b0;
    g_eop  = 1'b0;
    g_flit = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) begin
        g_vc   = bus.in_vc[i*VCW +: VCW];
        g_sop  = bus.in_sop[i];
        g_eop  = bus.in_eop[i];
        g_flit = bus.in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    lock_vld_d   = lock_vld_q;
    lock_own_d   = lock_own_q;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    proto_err_d  = proto_err_q | (|perr);
    stall_d      = stall_q | perr;
    out_d        = '0;
    if (gnt_any) begin
      ptr_d      = (gnt_idx == IW'(NUM_INPUTS - 1)) ? '0 : gnt_idx + IW'(1);
      out_d.vld  = 1'b1;
      out_d.vc   = g_vc;
      out_d.sop  = g_sop;
      out_d.eop  = g_eop;
      out_d.flit = g_flit;
      if (g_sop && !g_eop) begin
        lock_vld_d[g_vc] = 1'b1;
        lock_own_d[g_vc] = gnt_idx;
      end else if (g_eop) begin
        lock_vld_d[g_vc] = 1'b0;
      end
    end
    // a return at full credit is an upstream bookkeeping bug: hold the count, flag it
    for (int c = 0; c < CHANNELS; c++) begin
      if (gnt_any && (g_vc == VCW'(c)) && !bus.credit_return[c]) begin
        credit_d[c] = credit_q[c] - CW'(1);
      end else if (bus.credit_return[c] && !(gnt_any && (g_vc == VCW'(c)))) begin
        if (credit_q[c] == CW'(CREDIT_DEPTH)) begin
          credit_err_d = 1'b1;
        end else begin
          credit_d[c] = credit_q[c] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        credit_q[c]   <= CW'(CREDIT_DEPTH);
        lock_own_q[c] <= '0;
      end
      lock_vld_q   <= '0;
      ptr_q        <= '0;
      stall_q      <= '0;
      credit_err_q <= 1'b0;
      proto_err_q  <= 1'b0;
      run_q        <= 1'b0;
      out_q        <= '0;
    end else begin
      credit_q     <= credit_d;
      lock_own_q   <= lock_own_d;
      lock_vld_q   <= lock_vld_d;
      ptr_q        <= ptr_d;
      stall_q      <= stall_d;
      credit_err_q <= credit_err_d;
      proto_err_q  <= proto_err_d;
      run_q        <= 1'b1;
      out_q        <= out_d;
    end
  end

  assign bus.in_ready   = grant;
  assign bus.out_valid  = out_q.vld;
  assign bus.out_vc     = out_q.vc;
  assign bus.out_sop    = out_q.sop;
  assign bus.out_eop    = out_q.eop;
  assign bus.out_flit   = out_q.flit;
  assign bus.vc_busy    = lock_vld_q;
  assign bus.credit_err = credit_err_q;
  assign bus.proto_err  = proto_err_q;
endmodule
